// File: rtl/fifo1_deq_serializer.sv
// Single-element FIFO reader: dequeues one wide element and emits it LSB-first as narrow beats.
// Optional: define FIFO1_DEQ_SERIALIZER_LAST_EN to add out_enq_last marking each element's final beat.
module fifo1_deq_serializer #(
  parameter int DATA_WIDTH = 704,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [DATA_WIDTH-1:0] in_first,
  input  logic                  in_first_rdy,
  input  logic                  in_deq_rdy,
  output logic                  in_deq_ena,
  output logic [BEAT_WIDTH-1:0] out_enq_v,
  output logic                  out_enq_ena,
  input  logic                  out_enq_rdy,
  output logic                  busy
`ifdef FIFO1_DEQ_SERIALIZER_LAST_EN
  ,
  output logic                  out_enq_last
`endif
);

  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  take;
  logic                  last_beat;

  assign take        = in_deq_rdy && in_first_rdy;
  assign last_beat   = (state == SEND) && (cnt == LAST);
  // Reload on the accepted last beat keeps the beat stream gap-free across elements.
  assign in_deq_ena  = take && ((state == IDLE) || (last_beat && out_enq_rdy));
  assign out_enq_ena = (state == SEND) && out_enq_rdy;
  assign out_enq_v   = shreg[BEAT_WIDTH-1:0];
  assign busy        = (state == SEND);

`ifdef FIFO1_DEQ_SERIALIZER_LAST_EN
  assign out_enq_last = last_beat;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shreg <= in_first;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_enq_rdy) begin
            if (cnt != LAST) begin
              shreg <= shreg >> BEAT_WIDTH;
              cnt   <= cnt + CW'(1);
            end else if (take) begin
              shreg <= in_first;
              cnt   <= '0;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo1_deq_serializer.sv
// Bench for fifo1_deq_serializer: directed scenarios plus random traffic against a beat-queue model.
module tb_fifo1_deq_serializer;
  localparam int DW = 704;
  localparam int BW = 32;
  localparam int NB = DW / BW;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [DW-1:0] in_first = '0;
  logic          in_first_rdy = 1'b0;
  logic          in_deq_rdy = 1'b0;
  logic          in_deq_ena;
  logic [BW-1:0] out_enq_v;
  logic          out_enq_ena;
  logic          out_enq_rdy = 1'b0;
  logic          busy;
`ifdef FIFO1_DEQ_SERIALIZER_LAST_EN
  logic          out_enq_last;
`endif

  fifo1_deq_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_first     (in_first),
    .in_first_rdy (in_first_rdy),
    .in_deq_rdy   (in_deq_rdy),
    .in_deq_ena   (in_deq_ena),
    .out_enq_v    (out_enq_v),
    .out_enq_ena  (out_enq_ena),
    .out_enq_rdy  (out_enq_rdy),
    .busy         (busy)
`ifdef FIFO1_DEQ_SERIALIZER_LAST_EN
    ,
    .out_enq_last (out_enq_last)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int n_deq = 0;
  int n_beats = 0;
  logic [BW-1:0] mq[$];  // beats still owed downstream, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input logic [31:0] base);
    logic [DW-1:0] e;
    for (int k = 0; k < NB; k++) e[k*BW +: BW] = base + 32'(k);
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_elem();
    logic [DW-1:0] e;
    for (int k = 0; k < NB; k++) e[k*BW +: BW] = $urandom;
    return e;
  endfunction

  // One clock: drive inputs, check against model at negedge, advance model.
  task automatic cycle(input logic [DW-1:0] f, input logic fr, input logic dr, input logic er);
    logic take, exp_deq, held;
    in_first = f; in_first_rdy = fr; in_deq_rdy = dr; out_enq_rdy = er;
    @(negedge CLK);
    take    = fr && dr;
    held    = mq.size() > 0;
    exp_deq = take && (!held || (mq.size() == 1 && er));
    chk("in_deq_ena", 32'(in_deq_ena), 32'(exp_deq));
    chk("out_enq_ena", 32'(out_enq_ena), 32'(held && er));
    chk("busy", 32'(busy), 32'(held));
    if (held) chk("out_enq_v", out_enq_v, mq[0]);
`ifdef FIFO1_DEQ_SERIALIZER_LAST_EN
    chk("out_enq_last", 32'(out_enq_last), 32'(mq.size() == 1));
`endif
    if (held && er) begin
      void'(mq.pop_front());
      n_beats++;
    end
    if (exp_deq) begin
      n_deq++;
      for (int k = 0; k < NB; k++) mq.push_back(f[k*BW +: BW]);
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    in_first_rdy = 1'b0; in_deq_rdy = 1'b0; out_enq_rdy = 1'b0;
    nRST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enq_ena", 32'(out_enq_ena), 32'd0);
    chk("rst_deq_ena", 32'(in_deq_ena), 32'd0);
    chk("rst_enq_v", out_enq_v, 32'd0);
`ifdef FIFO1_DEQ_SERIALIZER_LAST_EN
    chk("rst_last", 32'(out_enq_last), 32'd0);
`endif
    mq.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] e1, e2;
    int got;

    // Reset, then one patterned element at full rate
    do_reset();
    n_deq = 0; n_beats = 0;
    cycle(pattern(32'hA000_0000), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < NB + 4; i++) cycle('0, 1'b0, 1'b0, 1'b1);
    chk("single_deqs", 32'(n_deq), 32'd1);
    chk("single_beats", 32'(n_beats), 32'(NB));

    // Backpressure 1,0,0 repeating
    n_beats = 0;
    cycle(rnd_elem(), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3 * NB + 6; i++) cycle('0, 1'b0, 1'b0, (i % 3) == 0);
    chk("bp_beats", 32'(n_beats), 32'(NB));
    chk("bp_idle", 32'(mq.size()), 32'd0);

    // Back-to-back: take held high until both elements are dequeued
    e1 = pattern(32'h1111_0000);
    e2 = pattern(32'h2222_0000);
    n_deq = 0; n_beats = 0;
    for (int i = 0; i < 2 * NB + 4; i++) begin
      if (n_deq == 0) cycle(e1, 1'b1, 1'b1, 1'b1);
      else if (n_deq == 1) cycle(e2, 1'b1, 1'b1, 1'b1);
      else cycle('0, 1'b0, 1'b0, 1'b1);
      if (i == 2 * NB) chk("b2b_beats_no_gap", 32'(n_beats), 32'(2 * NB));
    end
    chk("b2b_deqs", 32'(n_deq), 32'd2);

    // Empty source
    for (int i = 0; i < 50; i++) cycle(rnd_elem(), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // FIFO head valid but deq not ready
    n_deq = 0;
    for (int i = 0; i < 10; i++) cycle(rnd_elem(), 1'b1, 1'b0, 1'b1);
    chk("nodeq_deqs", 32'(n_deq), 32'd0);

    // Reset after beat 5 of an element, then a fresh element restarts at beat 0
    cycle(pattern(32'hB000_0000), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle('0, 1'b0, 1'b0, 1'b1);
    do_reset();
    n_beats = 0;
    cycle(pattern(32'hC000_0000), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < NB + 2; i++) cycle('0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_beats", 32'(n_beats), 32'(NB));

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cycle(rnd_elem(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0));
    got = mq.size();
    for (int i = 0; i < NB * 4 && mq.size() > 0; i++) cycle('0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", 32'(mq.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
    if (got > NB) chk("drain_bound", 32'(got), 32'(NB));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo1_deq_serializer.md
Name: fifo1_deq_serializer

Overview:
- Reader-side companion to the single-element FIFO: sits on the FIFO's dequeue/first method interface.
- Pulls one DATA_WIDTH element, then emits it downstream as BEATS narrow beats through an enq-style ENA/RDY method interface.
- Used wherever a wide 704-bit FIFO element must feed a narrow (32-bit) consumer.
- Zero-bubble: the next element is loaded in the same cycle the last beat of the current one is accepted.

Parameters:
- DATA_WIDTH, 704, width of a FIFO element.
- BEAT_WIDTH, 32, width of one output beat; DATA_WIDTH must be an exact multiple of it.
- BEATS, DATA_WIDTH/BEAT_WIDTH (22), derived beats per element; not overridden independently.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset.
- in_first  input  DATA_WIDTH  FIFO head element (FIFO out$first).
- in_first_rdy  input  1  head valid (FIFO out$first__RDY).
- in_deq_rdy  input  1  FIFO can dequeue (FIFO out$deq__RDY).
- in_deq_ena  output  1  dequeue strobe to the FIFO (drives out$deq__ENA).
- out_enq_v  output  BEAT_WIDTH  beat data.
- out_enq_ena  output  1  beat strobe, one beat transferred per cycle high.
- out_enq_rdy  input  1  downstream can accept a beat.
- busy  output  1  high while an element is held.

Interface note: reset nRST, synchronous, active-low; clock CLK.

Behaviour:
- Registers:
  - shreg (DATA_WIDTH)
  - cnt, range 0..BEATS-1, width $clog2(BEATS)
  - state: IDLE or SEND
- Reset, sampled at posedge CLK with nRST=0: state=IDLE, cnt=0, shreg=0.
  - Resulting outputs: in_deq_ena=0, out_enq_ena=0, out_enq_v=0, busy=0.
  - Reset mid-element discards the held element and all remaining beats. An element already dequeued is lost; this is intended.
- take = in_deq_rdy && in_first_rdy. Combinational.
- in_deq_ena = take && (state==IDLE || (state==SEND && cnt==BEATS-1 && out_enq_rdy)). Combinational.
- out_enq_ena = (state==SEND) && out_enq_rdy. Combinational; never asserted in IDLE.
- out_enq_v = shreg[BEAT_WIDTH-1:0]. Beats go LSB-first: beat k = element bits [k*BEAT_WIDTH +: BEAT_WIDTH].
- busy = (state==SEND).
- IDLE:
  - If take: shreg<=in_first, cnt<=0, state<=SEND. The FIFO is dequeued in that same cycle.
  - Otherwise hold.
- SEND, out_enq_rdy=0: hold everything; out_enq_v stays stable (backpressure).
- SEND, out_enq_rdy=1, cnt<BEATS-1: shreg <= shreg >> BEAT_WIDTH (zero fill), cnt<=cnt+1.
- SEND, out_enq_rdy=1, cnt==BEATS-1 (last beat):
  - If take: shreg<=in_first, cnt<=0, stay in SEND, dequeue this cycle (back-to-back, no idle cycle).
  - Otherwise: state<=IDLE, cnt<=0.
- Latency: the first beat is visible the cycle after the dequeue. Element throughput is one per BEATS cycles at full rate.
- in_first is sampled only in a cycle where in_deq_ena=1. It is ignored in all other cycles.
- in_first_rdy=1 with in_deq_rdy=0 is treated as not-ready; no dequeue.

Optional Feature:
- Macro FIFO1_DEQ_SERIALIZER_LAST_EN.
- Defined:
  - Adds output out_enq_last (1 bit) = (state==SEND) && (cnt==BEATS-1).
  - out_enq_last is 0 in reset; it qualifies the final beat of each element.
  - It is valid whenever out_enq_ena is high and stable under backpressure.
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Reset then one element, beat k = 32'hA000_0000+k, k=0..21; take=1 one cycle, out_enq_rdy=1 → in_deq_ena one cycle; 22 consecutive beats 32'hA0000000..32'hA0000015 starting next cycle; busy drops after beat 21; (LAST_EN) out_enq_last only on 32'hA0000015.
- Backpressure: out_enq_rdy toggles 1,0,0,1,... during an element → beat value held while rdy=0; no beat skipped or duplicated; total 22 beats.
- Back-to-back: two elements (0x11..., 0x22... patterns) queued, take held high → second in_deq_ena coincides with the last beat of the first; 44 beats with no gap cycle.
- Empty source: take=0 for 50 cycles → in_deq_ena=0, out_enq_ena=0, busy=0 throughout.
- Reset mid-element: nRST=0 after beat 5 → next cycle out_enq_ena=0, busy=0, cnt=0; after release a new element restarts at beat 0.
- in_first_rdy=1, in_deq_rdy=0 → no dequeue, no beats.
